// File: rtl/instruction_pkg.sv
// -----------------------------------------------------------------------------
// instruction_pkg
// Shared types for the instruction trace path.
//   trace_entry_t : one 136-bit trace record (retire, writeback, redirect groups)
//   ENTRY_W       : width of trace_entry_t in bits
//   pack_entry()  : builds an entry, zeroing the data of any group whose flag
//                   is low so that stale bus values never reach the trace.
// -----------------------------------------------------------------------------
package instruction_pkg;

   localparam int unsigned ENTRY_W = 136;

   typedef struct packed {
      logic        ret_valid;
      logic [31:0] ret_pc;
      logic [31:0] ret_inst;
      logic        wb_valid;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        br_valid;
      logic [31:0] br_pc;
   } trace_entry_t;

   function automatic trace_entry_t pack_entry(
      input logic        ret_v,
      input logic [31:0] ret_pc,
      input logic [31:0] ret_inst,
      input logic        wb_v,
      input logic [4:0]  wb_rd,
      input logic [31:0] wb_data,
      input logic        br_v,
      input logic [31:0] br_pc
   );
      trace_entry_t e;
      e = trace_entry_t'({ENTRY_W{1'b0}});
      e.ret_valid = ret_v;
      e.wb_valid  = wb_v;
      e.br_valid  = br_v;
      if (ret_v) begin
         e.ret_pc   = ret_pc;
         e.ret_inst = ret_inst;
      end else begin
         e.ret_pc   = 32'h0000_0000;
         e.ret_inst = 32'h0000_0000;
      end
      if (wb_v) begin
         e.wb_rd   = wb_rd;
         e.wb_data = wb_data;
      end else begin
         e.wb_rd   = 5'd0;
         e.wb_data = 32'h0000_0000;
      end
      if (br_v) begin
         e.br_pc = br_pc;
      end else begin
         e.br_pc = 32'h0000_0000;
      end
      return e;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// First-word fall-through FIFO of trace_entry_t records.
//   clk, reset   : clock, asynchronous active-low reset
//   wr_en/wr_data: push request (ignored while full)
//   rd_en        : pop request (ignored while empty)
//   rd_data      : head entry, all-zero while empty
//   empty, full  : occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module trace_fifo
   import instruction_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  trace_entry_t wr_data,
   input  logic         rd_en,
   output trace_entry_t rd_data,
   output logic         empty,
   output logic         full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   trace_entry_t     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [OCC_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   // Full is judged on the registered count only: a same-cycle pop never frees a slot early.
   assign full   = (count_r == OCC_W'(DEPTH));
   assign empty  = (count_r == OCC_W'(0));
   assign push_s = wr_en & ~full;
   assign pop_s  = rd_en & ~empty;

   // Storage array; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= OCC_W'(0);
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + OCC_W'(1);
            2'b01:   count_r <= count_r - OCC_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head presentation, forced to zero when nothing is queued.
   always_comb begin
      rd_data = trace_entry_t'({ENTRY_W{1'b0}});
      if (!empty) begin
         rd_data = mem_r[rd_ptr_r];
      end else begin
         rd_data = trace_entry_t'({ENTRY_W{1'b0}});
      end
   end

endmodule

// File: rtl/trace_gen.sv
// -----------------------------------------------------------------------------
// trace_gen
// Packs retire / writeback / redirect events into one trace entry per cycle
// and queues them for a trace consumer.
//   clk, reset                  : clock, asynchronous active-low reset
//   ret_valid/ret_pc/ret_inst   : retire event
//   wb_valid/wb_rd/wb_data      : register writeback event
//   br_valid/br_pc              : PC redirect event
//   in_ready                    : queue not full; producer holds inputs while low
//   out_ready                   : consumer takes the head entry
//   valid/pc/inst, rdv/rd_x/rd_data, pcv/pc_x : head entry fields (0 when empty)
//   ret_cnt                     : accepted retire count, wraps at 2^CNT_W
// Build option: TRACE_X0_FILTER_EN drops writebacks to x0 before packing.
// -----------------------------------------------------------------------------
module trace_gen
   import instruction_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ret_valid,
   input  logic [31:0]      ret_pc,
   input  logic [31:0]      ret_inst,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data,
   input  logic             br_valid,
   input  logic [31:0]      br_pc,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             valid,
   output logic [31:0]      pc,
   output logic [31:0]      inst,
   output logic             rdv,
   output logic [4:0]       rd_x,
   output logic [31:0]      rd_data,
   output logic             pcv,
   output logic [31:0]      pc_x,
   output logic [CNT_W-1:0] ret_cnt
);

   logic             wb_eff_s;
   logic             any_s;
   logic             push_s;
   logic             full_s;
   logic             empty_s;
   trace_entry_t     entry_s;
   trace_entry_t     head_s;
   logic [CNT_W-1:0] ret_cnt_r;

`ifdef TRACE_X0_FILTER_EN
   // x0 writes carry no architectural state, so they are not traced.
   assign wb_eff_s = wb_valid & (wb_rd != 5'd0);
`else
   assign wb_eff_s = wb_valid;
`endif

   assign entry_s  = pack_entry(ret_valid, ret_pc, ret_inst,
                                wb_eff_s, wb_rd, wb_data,
                                br_valid, br_pc);
   // An entry with no surviving event is never written.
   assign any_s    = ret_valid | wb_eff_s | br_valid;
   assign in_ready = ~full_s;
   assign push_s   = any_s & ~full_s;

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_s),
      .wr_data (entry_s),
      .rd_en   (out_ready),
      .rd_data (head_s),
      .empty   (empty_s),
      .full    (full_s)
   );

   // Retire counter, advanced only by accepted pushes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ret_cnt_r <= CNT_W'(0);
      end else if (push_s && ret_valid) begin
         ret_cnt_r <= ret_cnt_r + CNT_W'(1);
      end
   end

   assign ret_cnt = ret_cnt_r;
   assign valid   = head_s.ret_valid;
   assign pc      = head_s.ret_pc;
   assign inst    = head_s.ret_inst;
   assign rdv     = head_s.wb_valid;
   assign rd_x    = head_s.wb_rd;
   assign rd_data = head_s.wb_data;
   assign pcv     = head_s.br_valid;
   assign pc_x    = head_s.br_pc;

   // empty_s is consumed inside the FIFO's head masking; kept here for debug visibility.
   logic unused_s;
   assign unused_s = empty_s;

endmodule

// File: tb/tb_trace_gen.sv
module tb_trace_gen;

   logic        clk;
   logic        reset;
   logic        ret_valid;
   logic [31:0] ret_pc;
   logic [31:0] ret_inst;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        br_valid;
   logic [31:0] br_pc;
   logic        in_ready;
   logic        out_ready;
   logic        valid;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        rdv;
   logic [4:0]  rd_x;
   logic [31:0] rd_data;
   logic        pcv;
   logic [31:0] pc_x;
   logic [31:0] ret_cnt;

   int          vecs;
   int          errs;
   logic [31:0] exp_cnt;

   trace_gen #(.DEPTH(4), .CNT_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .ret_valid (ret_valid),
      .ret_pc    (ret_pc),
      .ret_inst  (ret_inst),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .br_valid  (br_valid),
      .br_pc     (br_pc),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .valid     (valid),
      .pc        (pc),
      .inst      (inst),
      .rdv       (rdv),
      .rd_x      (rd_x),
      .rd_data   (rd_data),
      .pcv       (pcv),
      .pc_x      (pc_x),
      .ret_cnt   (ret_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      ret_valid = 1'b0; ret_pc = 32'h0; ret_inst = 32'h0;
      wb_valid  = 1'b0; wb_rd  = 5'd0;  wb_data  = 32'h0;
      br_valid  = 1'b0; br_pc  = 32'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      out_ready = 1'b0;
      clear_inputs();
      #12;
      vecs++; if ({valid, rdv, pcv} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b expected 000", {valid, rdv, pcv}); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      vecs++; if (ret_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt: got %0d expected 0", ret_cnt); end
      @(negedge clk);
      reset = 1'b1;
      step();
      vecs++; if ({valid, rdv, pcv, in_ready} !== 4'b0001) begin errs++; $display("FAIL post_reset: got %b expected 0001", {valid, rdv, pcv, in_ready}); end
      vecs++; if (pc !== 32'h0 || pc_x !== 32'h0 || rd_data !== 32'h0) begin errs++; $display("FAIL post_reset_data: got %h/%h/%h expected 0", pc, pc_x, rd_data); end
      exp_cnt = 32'd0;
   endtask

   task automatic test_single_retire();
      out_ready = 1'b0;
      ret_valid = 1'b1; ret_pc = 32'h0000_0010; ret_inst = 32'h0050_0093;
      step();
      clear_inputs();
      exp_cnt = exp_cnt + 32'd1;
      vecs++; if (valid !== 1'b1 || pc !== 32'h0000_0010 || inst !== 32'h0050_0093) begin errs++; $display("FAIL single_ret: got %b %h %h expected 1 00000010 00500093", valid, pc, inst); end
      vecs++; if (rdv !== 1'b0 || pcv !== 1'b0 || rd_data !== 32'h0 || pc_x !== 32'h0) begin errs++; $display("FAIL single_other: got %b %b %h %h expected 0 0 0 0", rdv, pcv, rd_data, pc_x); end
      vecs++; if (ret_cnt !== 32'd1) begin errs++; $display("FAIL single_cnt: got %0d expected 1", ret_cnt); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vecs++; if (valid !== 1'b0 || pc !== 32'h0) begin errs++; $display("FAIL single_pop: got %b %h expected 0 0", valid, pc); end
   endtask

   task automatic test_all_groups();
      out_ready = 1'b0;
      ret_valid = 1'b1; ret_pc = 32'h0000_0020; ret_inst = 32'h0000_0013;
      wb_valid  = 1'b1; wb_rd  = 5'd1;          wb_data  = 32'h0000_0005;
      br_valid  = 1'b1; br_pc  = 32'h0000_0100;
      step();
      clear_inputs();
      exp_cnt = exp_cnt + 32'd1;
      vecs++; if ({valid, rdv, pcv} !== 3'b111) begin errs++; $display("FAIL all_flags: got %b expected 111", {valid, rdv, pcv}); end
      vecs++; if (rd_x !== 5'd1 || rd_data !== 32'h5 || pc_x !== 32'h100 || pc !== 32'h20) begin errs++; $display("FAIL all_data: got %0d %h %h %h expected 1 5 100 20", rd_x, rd_data, pc_x, pc); end
      vecs++; if (ret_cnt !== exp_cnt) begin errs++; $display("FAIL all_cnt: got %0d expected %0d", ret_cnt, exp_cnt); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vecs++; if ({valid, rdv, pcv} !== 3'b000) begin errs++; $display("FAIL all_pop: got %b expected 000", {valid, rdv, pcv}); end
   endtask

   task automatic test_zero_fields();
      out_ready = 1'b0;
      ret_valid = 1'b0; ret_pc = 32'hDEAD_BEEF; ret_inst = 32'h1111_1111;
      wb_valid  = 1'b0; wb_rd  = 5'd7;          wb_data  = 32'h0000_0055;
      br_valid  = 1'b1; br_pc  = 32'h0000_0200;
      step();
      clear_inputs();
      vecs++; if ({valid, rdv, pcv} !== 3'b001 || pc_x !== 32'h200) begin errs++; $display("FAIL zero_flags: got %b %h expected 001 00000200", {valid, rdv, pcv}, pc_x); end
      vecs++; if (pc !== 32'h0 || inst !== 32'h0 || rd_x !== 5'd0 || rd_data !== 32'h0) begin errs++; $display("FAIL zero_data: got %h %h %0d %h expected 0", pc, inst, rd_x, rd_data); end
      vecs++; if (ret_cnt !== exp_cnt) begin errs++; $display("FAIL zero_cnt: got %0d expected %0d", ret_cnt, exp_cnt); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_x0();
      out_ready = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
      step();
      clear_inputs();
`ifdef TRACE_X0_FILTER_EN
      vecs++; if ({valid, rdv, pcv} !== 3'b000 || rd_data !== 32'h0) begin errs++; $display("FAIL x0_filtered: got %b %h expected 000 0", {valid, rdv, pcv}, rd_data); end
`else
      vecs++; if ({valid, rdv, pcv} !== 3'b010 || rd_x !== 5'd0 || rd_data !== 32'h1234) begin errs++; $display("FAIL x0_traced: got %b %0d %h expected 010 0 1234", {valid, rdv, pcv}, rd_x, rd_data); end
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vecs++; if (rdv !== 1'b0) begin errs++; $display("FAIL x0_drain: got %b expected 0", rdv); end
   endtask

   task automatic test_backpressure();
      int  n;
      logic pending;
      logic rdy_before;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ret_valid = 1'b1; ret_pc = 32'h0000_1000 + 32'(i * 4); ret_inst = 32'(i);
         step();
         exp_cnt = exp_cnt + 32'd1;
         vecs++; if (in_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin errs++; $display("FAIL bp_in_ready%0d: got %b expected %b", i, in_ready, (i < 3)); end
      end
      ret_valid = 1'b1; ret_pc = 32'h0000_1010; ret_inst = 32'd4;
      for (int h = 0; h < 3; h++) begin
         step();
         vecs++; if (in_ready !== 1'b0 || pc !== 32'h0000_1000) begin errs++; $display("FAIL bp_hold%0d: got %b %h expected 0 00001000", h, in_ready, pc); end
      end
      vecs++; if (ret_cnt !== exp_cnt) begin errs++; $display("FAIL bp_hold_cnt: got %0d expected %0d", ret_cnt, exp_cnt); end
      out_ready = 1'b1;
      n = 0;
      pending = 1'b1;
      for (int c = 0; c < 12 && n < 5; c++) begin
         if (valid === 1'b1) begin
            vecs++; if (pc !== 32'h0000_1000 + 32'(n * 4) || inst !== 32'(n)) begin errs++; $display("FAIL bp_order%0d: got %h %h expected %h %h", n, pc, inst, 32'h0000_1000 + 32'(n * 4), n); end
            n++;
         end
         rdy_before = in_ready;
         step();
         if (pending && rdy_before) begin
            pending = 1'b0;
            clear_inputs();
            exp_cnt = exp_cnt + 32'd1;
         end
      end
      clear_inputs();
      vecs++; if (n !== 5 || pending !== 1'b0) begin errs++; $display("FAIL bp_count: got %0d entries pending=%b expected 5 pending=0", n, pending); end
      vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL bp_no_dup: got %b expected 0", valid); end
      vecs++; if (ret_cnt !== exp_cnt) begin errs++; $display("FAIL bp_cnt: got %0d expected %0d", ret_cnt, exp_cnt); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ret_valid = 1'b1; ret_pc = 32'h0000_2000 + 32'(i * 4); ret_inst = 32'h0000_0013;
         step();
      end
      clear_inputs();
      vecs++; if (valid !== 1'b1 || pc !== 32'h0000_2000) begin errs++; $display("FAIL mid_queued: got %b %h expected 1 00002000", valid, pc); end
      reset = 1'b0;
      #2;
      vecs++; if ({valid, rdv, pcv} !== 3'b000 || pc !== 32'h0 || inst !== 32'h0) begin errs++; $display("FAIL mid_outputs: got %b %h %h expected 000 0 0", {valid, rdv, pcv}, pc, inst); end
      vecs++; if (in_ready !== 1'b1 || ret_cnt !== 32'd0) begin errs++; $display("FAIL mid_state: got %b %0d expected 1 0", in_ready, ret_cnt); end
      #2;
      reset = 1'b1;
      exp_cnt = 32'd0;
      ret_valid = 1'b1; ret_pc = 32'h0000_3000; ret_inst = 32'h0000_0033;
      step();
      clear_inputs();
      exp_cnt = exp_cnt + 32'd1;
      vecs++; if (valid !== 1'b1 || pc !== 32'h0000_3000 || ret_cnt !== exp_cnt) begin errs++; $display("FAIL mid_push: got %b %h %0d expected 1 00003000 1", valid, pc, ret_cnt); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL mid_alone: got %b expected 0", valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ret_valid = 1'b1; ret_pc = 32'h0000_4000 + 32'(k * 4); ret_inst = 32'(k);
         step();
         exp_cnt = exp_cnt + 32'd1;
      end
      out_ready = 1'b1;
      for (int k = 2; k < 22; k++) begin
         ret_valid = 1'b1; ret_pc = 32'h0000_4000 + 32'(k * 4); ret_inst = 32'(k);
         step();
         exp_cnt = exp_cnt + 32'd1;
         vecs++; if (valid !== 1'b1 || in_ready !== 1'b1 || pc !== 32'h0000_4000 + 32'((k - 1) * 4) || inst !== 32'(k - 1)) begin errs++; $display("FAIL stream%0d: got %b %b %h expected 1 1 %h", k, valid, in_ready, pc, 32'h0000_4000 + 32'((k - 1) * 4)); end
      end
      clear_inputs();
      step();
      vecs++; if (valid !== 1'b1 || pc !== 32'h0000_4054) begin errs++; $display("FAIL stream_tail: got %b %h expected 1 00004054", valid, pc); end
      step();
      vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL stream_empty: got %b expected 0", valid); end
      vecs++; if (ret_cnt !== exp_cnt) begin errs++; $display("FAIL stream_cnt: got %0d expected %0d", ret_cnt, exp_cnt); end
      out_ready = 1'b0;
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      exp_cnt = 32'd0;
      test_reset();
      test_single_retire();
      test_all_groups();
      test_zero_fields();
      test_x0();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
